rx_comma_aligner: RTL and testbench

//  Receive-side bit aligner for the PCIe interface. Deserializes the 1-bit line

---
 rtl/rx_comma_aligner.sv | 179 +++++++++++++++++
 tb/tb_rx_comma_aligner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_comma_aligner.sv
// Receive bit aligner: shifts in the serial line, hunts for K28.5 in either
// disparity, locks the 10-bit boundary and strobes aligned symbols downstream.
module rx_comma_aligner #(
   parameter int LOCK_COMMAS = 2,
   parameter int LOSS_ERRS   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enb,
   input  logic       elecIdle,
   input  logic       serialIn,
   output logic [9:0] symOut,
   output logic       symValid,
   output logic       isComma,
   output logic       locked,
   output logic       alignErr
);

   localparam int               SYM_W     = 10;
   localparam logic [SYM_W-1:0] COMMA_RDN = 10'b0011111010;
   localparam logic [SYM_W-1:0] COMMA_RDP = 10'b1100000101;
   localparam logic [3:0]       LAST_BIT  = 4'd9;
   localparam logic [2:0]       LOCK_N    = 3'(LOCK_COMMAS);
   localparam logic [2:0]       LOSS_N    = 3'(LOSS_ERRS);

   localparam logic [1:0] ST_UNLOCKED = 2'd0;
   localparam logic [1:0] ST_CHECK    = 2'd1;
   localparam logic [1:0] ST_LOCKED   = 2'd2;

   logic [SYM_W-1:0] sr_p0;
   logic [SYM_W-1:0] srNxt;
   logic [3:0]       bitCnt;
   logic [3:0]       bitCntNxt;
   logic [2:0]       commaCnt;
   logic [2:0]       commaCntNxt;
   logic [2:0]       errCnt;
   logic [2:0]       errCntNxt;
   logic [2:0]       commaInc;
   logic [2:0]       errInc;
   logic [1:0]       state;
   logic [1:0]       stateNxt;
   logic [SYM_W-1:0] symOutNxt;
   logic             symValidNxt;
   logic             isCommaNxt;
   logic             lockedNxt;
   logic             alignErrNxt;
   logic             commaDet;
   logic             boundary;

   function automatic logic [2:0] satInc(input logic [2:0] cnt, input logic [2:0] lim);
      return (cnt >= lim) ? lim : cnt + 3'd1;
   endfunction

   function automatic logic [3:0] bitWrap(input logic [3:0] cnt);
      return (cnt >= LAST_BIT) ? 4'd0 : cnt + 4'd1;
   endfunction

   // Stage p0: the shift register holds the last ten line bits, newest in bit 0
   assign commaDet = (sr_p0 == COMMA_RDN) || (sr_p0 == COMMA_RDP);
   assign boundary = (bitCnt == 4'd0);
   assign commaInc = satInc(commaCnt, LOCK_N);
   assign errInc   = satInc(errCnt, LOSS_N);

   always_comb begin
      srNxt       = sr_p0;
      bitCntNxt   = bitCnt;
      commaCntNxt = commaCnt;
      errCntNxt   = errCnt;
      stateNxt    = state;
      symOutNxt   = symOut;
      lockedNxt   = locked;
      symValidNxt = 1'b0;
      isCommaNxt  = 1'b0;
      alignErrNxt = 1'b0;

      if (enb) begin
         srNxt = {sr_p0[SYM_W-2:0], serialIn};
      end

      if (elecIdle) begin
         stateNxt    = ST_UNLOCKED;
         lockedNxt   = 1'b0;
         bitCntNxt   = 4'd0;
         commaCntNxt = 3'd0;
         errCntNxt   = 3'd0;
      end else if (enb) begin
         bitCntNxt = bitWrap(bitCnt);
         case (state)
            ST_UNLOCKED: begin
               if (commaDet) begin
                  // The comma's last bit is already in sr; the next bit starts a symbol.
                  bitCntNxt   = 4'd1;
                  commaCntNxt = 3'd1;
                  if (LOCK_COMMAS == 1) begin
                     stateNxt    = ST_LOCKED;
                     lockedNxt   = 1'b1;
                     symOutNxt   = sr_p0;
                     symValidNxt = 1'b1;
                     isCommaNxt  = 1'b1;
                  end else begin
                     stateNxt = ST_CHECK;
                  end
               end
            end

            ST_CHECK: begin
               if (commaDet && boundary) begin
                  commaCntNxt = commaInc;
                  if (commaInc == LOCK_N) begin
                     stateNxt    = ST_LOCKED;
                     lockedNxt   = 1'b1;
                     symOutNxt   = sr_p0;
                     symValidNxt = 1'b1;
                     isCommaNxt  = 1'b1;
                  end
               end else if (commaDet) begin
                  // Off-boundary comma wins over the wrap of bitCnt.
                  bitCntNxt   = 4'd1;
                  commaCntNxt = 3'd1;
               end
            end

            ST_LOCKED: begin
               if (boundary) begin
                  symOutNxt   = sr_p0;
                  symValidNxt = 1'b1;
                  isCommaNxt  = commaDet;
                  if (commaDet) begin
                     errCntNxt = 3'd0;
                  end
               end else if (commaDet) begin
                  alignErrNxt = 1'b1;
                  if (errInc == LOSS_N) begin
                     stateNxt    = ST_UNLOCKED;
                     lockedNxt   = 1'b0;
                     errCntNxt   = 3'd0;
                     commaCntNxt = 3'd0;
                  end else begin
                     errCntNxt = errInc;
                  end
               end
            end

            default: begin
               stateNxt  = ST_UNLOCKED;
               lockedNxt = 1'b0;
            end
         endcase
      end
   end

   // Stage p1: registered symbol, strobes and lock status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_p0    <= '0;
         bitCnt   <= 4'd0;
         commaCnt <= 3'd0;
         errCnt   <= 3'd0;
         state    <= ST_UNLOCKED;
         symOut   <= '0;
         symValid <= 1'b0;
         isComma  <= 1'b0;
         locked   <= 1'b0;
         alignErr <= 1'b0;
      end else begin
         sr_p0    <= srNxt;
         bitCnt   <= bitCntNxt;
         commaCnt <= commaCntNxt;
         errCnt   <= errCntNxt;
         state    <= stateNxt;
         symOut   <= symOutNxt;
         symValid <= symValidNxt;
         isComma  <= isCommaNxt;
         locked   <= lockedNxt;
         alignErr <= alignErrNxt;
      end
   end

endmodule

// File: tb/tb_rx_comma_aligner.sv
// Directed bench for rx_comma_aligner: symbol table for lock/data flow plus
// hand-written slip, idle, async-reset and enable-gating sequences.
module tb_rx_comma_aligner;

   localparam logic [9:0] K_RDN = 10'b0011111010;
   localparam logic [9:0] K_RDP = 10'b1100000101;
   localparam logic [9:0] D03   = 10'b1001110011;
   localparam logic [9:0] D21   = 10'b1010101010;

   logic       clk = 1'b0;
   logic       rst;
   logic       enb;
   logic       elecIdle;
   logic       serialIn;
   logic [9:0] symOut;
   logic       symValid;
   logic       isComma;
   logic       locked;
   logic       alignErr;

   int nChecks = 0;
   int nErrors = 0;
   int cyc     = 0;

   typedef struct {
      logic [9:0] sym;
      logic       expValid;
      logic       expComma;
      logic [9:0] expOut;
      logic       expLocked;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   rx_comma_aligner #(.LOCK_COMMAS(2), .LOSS_ERRS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .enb      (enb),
      .elecIdle (elecIdle),
      .serialIn (serialIn),
      .symOut   (symOut),
      .symValid (symValid),
      .isComma  (isComma),
      .locked   (locked),
      .alignErr (alignErr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input logic b, input logic en);
      serialIn = b;
      enb      = en;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic sendBits(input logic [9:0] s, input int hi, output int strobes);
      strobes = 0;
      for (int i = hi; i >= 0; i--) begin
         tick(s[i], 1'b1);
         if (symValid || alignErr) strobes++;
      end
   endtask

   task automatic chkSym(input string tag, input logic v, input logic c, input logic [9:0] o,
                         input logic l);
      chk({tag, " symValid"}, 32'(symValid), 32'(v));
      chk({tag, " isComma"},  32'(isComma),  32'(c));
      chk({tag, " symOut"},   32'(symOut),   32'(o));
      chk({tag, " locked"},   32'(locked),   32'(l));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   initial begin
      int         quiet;
      int         pulses;
      int         fallAt;
      int         lastPulseAt;
      int         n;
      int         start;
      int         bad;
      int         early;
      logic       lockedAt3;
      logic [9:0] s;
      logic [22:0] seq;

      rst      = 1'b1;
      enb      = 1'b1;
      elecIdle = 1'b0;
      serialIn = 1'b0;

      vecs[0] = '{K_RDN, 1'b0, 1'b0, 10'h000, 1'b0};
      vecs[1] = '{K_RDP, 1'b0, 1'b0, 10'h000, 1'b0};
      vecs[2] = '{D03,   1'b1, 1'b1, 10'h305, 1'b1};
      vecs[3] = '{D21,   1'b1, 1'b0, 10'h273, 1'b1};
      vecs[4] = '{K_RDN, 1'b1, 1'b0, 10'h2AA, 1'b1};
      vecs[5] = '{D21,   1'b1, 1'b1, 10'h0FA, 1'b1};

      // reset held with a random line
      for (int i = 0; i < 8; i++) begin
         tick(1'($urandom_range(0, 1)), 1'b1);
         chk($sformatf("reset outputs %0d", i),
             32'({symOut, symValid, isComma, locked, alignErr}), 32'd0);
      end
      rst = 1'b0;

      // junk then table of symbols: each record's expectation is the result of
      // the previous symbol, observed one edge after this symbol's first bit
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      for (int v = 0; v < 6; v++) begin
         s = vecs[v].sym;
         tick(s[9], 1'b1);
         chkSym($sformatf("vec%0d", v), vecs[v].expValid, vecs[v].expComma,
                vecs[v].expOut, vecs[v].expLocked);
         chk($sformatf("vec%0d alignErr", v), 32'(alignErr), 32'd0);
         sendBits(s, 8, quiet);
         chk($sformatf("vec%0d quiet", v), 32'(quiet), 32'd0);
      end

      // one extra bit slips the boundary; the last table symbol still emerges
      tick(1'b0, 1'b1);
      chkSym("slip last data", 1'b1, 1'b0, 10'h2AA, 1'b1);
      pulses      = 0;
      fallAt      = -1;
      lastPulseAt = -1;
      lockedAt3   = 1'b0;
      n           = 0;
      for (int c = 0; c < 6; c++) begin
         s = (c % 2 == 0) ? K_RDN : K_RDP;
         for (int i = 9; i >= 0; i--) begin
            tick(s[i], 1'b1);
            n++;
            if (alignErr) begin
               pulses++;
               lastPulseAt = n;
               if (pulses == 3) lockedAt3 = locked;
            end
            if (!locked && fallAt < 0) fallAt = n;
         end
      end
      chk("slip pulse count", 32'(pulses), 32'd4);
      chk("slip 4th pulse edge", 32'(lastPulseAt), 32'd41);
      chk("slip unlock edge", 32'(fallAt), 32'd41);
      chk("slip locked at 3rd pulse", 32'(lockedAt3), 32'd1);
      chk("slip not relocked early", 32'(locked), 32'd0);
      s = D03;
      tick(s[9], 1'b1);
      chkSym("slip relock", 1'b1, 1'b1, 10'h305, 1'b1);

      // electrical idle for one cycle on the edge that would strobe D0.3
      sendBits(D03, 8, quiet);
      chk("idle pre quiet", 32'(quiet), 32'd0);
      elecIdle = 1'b1;
      tick(1'b0, 1'b1);
      elecIdle = 1'b0;
      chk("idle locked", 32'(locked), 32'd0);
      chk("idle symValid", 32'(symValid), 32'd0);
      chk("idle alignErr", 32'(alignErr), 32'd0);
      sendBits(K_RDN, 9, quiet);
      tick(1'b1, 1'b1);
      chk("idle one comma", 32'(locked), 32'd0);
      sendBits(K_RDP, 8, quiet);
      tick(1'b0, 1'b1);
      chkSym("idle relock", 1'b1, 1'b1, 10'h305, 1'b1);

      // asynchronous reset mid-symbol clears without a clock edge
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async reset outputs",
          32'({symOut, symValid, isComma, locked, alignErr}), 32'd0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      rst = 1'b0;

      // enable toggling stretches the lock sequence by two
      start = cyc;
      bad   = 0;
      early = 0;
      seq   = {3'b101, K_RDN, K_RDP};
      for (int i = 22; i >= 0; i--) begin
         tick(seq[i], 1'b1);
         if (locked || symValid || alignErr) early++;
         tick(~seq[i], 1'b0);
         if (locked || symValid || alignErr) bad++;
      end
      chk("gated early activity", 32'(early), 32'd0);
      chk("gated disabled strobes", 32'(bad), 32'd0);
      tick(1'b0, 1'b1);
      chkSym("gated lock", 1'b1, 1'b1, 10'h305, 1'b1);
      chk("gated lock edge", 32'(cyc - start), 32'd47);
      tick(1'b1, 1'b0);
      chk("gated strobe width", 32'(symValid), 32'd0);
      chk("gated hold locked", 32'(locked), 32'd1);
      elecIdle = 1'b1;
      tick(1'b0, 1'b0);
      elecIdle = 1'b0;
      chk("idle while disabled", 32'(locked), 32'd0);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
